// File: rtl/vx_fpu_rsp_merge_pkg.sv
// Shared FPU response definitions: floating-point exception flag width and type.
// The response record itself depends on lane/tag widths, so it lives in the top.
package vx_fpu_rsp_merge_pkg;

    localparam int FP_FLAGS_BITS = 5;

    typedef logic [FP_FLAGS_BITS-1:0] fflags_t;

    // Flags without a valid indication are carried as zero so commit never sees junk.
    function automatic fflags_t mask_fflags(input fflags_t flags, input logic en);
        return en ? flags : '0;
    endfunction

endpackage

// File: rtl/vx_fpu_rsp_merge_rr_grant.sv
// Combinational round-robin pick: first valid input at or after index rr_i,
// returned both as a one-hot grant and as a binary index.
module vx_rr_grant #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] rr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!found && valid_i[(int'(rr_i) + off) % N]) begin
                found                                = 1'b1;
                grant_o[(int'(rr_i) + off) % N]      = 1'b1;
                idx_o                                = IDX_W'((int'(rr_i) + off) % N);
            end
        end
    end

endmodule

// File: rtl/vx_fpu_rsp_merge.sv
// Merges NUM_INPUTS FPU response streams into one commit-bound stream through a
// round-robin arbiter and a 2-entry elastic buffer; input ready never sees ready_out.
module vx_fpu_rsp_merge
    import vx_fpu_rsp_merge_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int NUM_LANES  = 5,
    parameter int TAG_WIDTH  = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_INPUTS-1:0]                     valid_in,
    output logic [NUM_INPUTS-1:0]                     ready_in,
    input  logic [NUM_INPUTS-1:0][NUM_LANES-1:0][31:0] result_in,
    input  logic [NUM_INPUTS-1:0]                     has_fflags_in,
    input  logic [NUM_INPUTS-1:0][FP_FLAGS_BITS-1:0]  fflags_in,
    input  logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]      tag_in,
    output logic                                      valid_out,
    input  logic                                      ready_out,
    output logic [NUM_LANES-1:0][31:0]                result_out,
    output logic                                      has_fflags_out,
    output logic [FP_FLAGS_BITS-1:0]                  fflags_out,
    output logic [TAG_WIDTH-1:0]                      tag_out
);

    localparam int IDX_W = $clog2(NUM_INPUTS);

    typedef struct packed {
        logic [NUM_LANES-1:0][31:0] result;
        logic                       has_fflags;
        fflags_t                    fflags;
        logic [TAG_WIDTH-1:0]       tag;
    } fpu_rsp_t;

    logic [NUM_INPUTS-1:0] grant;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [1:0]            count_q, count_d;
    logic                  head_q, head_d;
    fpu_rsp_t [1:0]        buf_q;
    fpu_rsp_t              in_rsp;
    fpu_rsp_t              head_rsp;
    logic                  can_push;
    logic                  push;
    logic                  pop;
    logic                  wr_ptr;

    vx_rr_grant #(
        .N     (NUM_INPUTS),
        .IDX_W (IDX_W)
    ) u_rr_grant (
        .valid_i (valid_in),
        .rr_i    (rr_q),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    // Valid/ready: a beat moves on a rising edge where both are high. Input ready
    // is built from registered occupancy and the valid-driven grant only.
    assign can_push = !reset && (count_q != 2'd2);
    assign ready_in = can_push ? grant : '0;
    assign push     = |(valid_in & ready_in);
    assign pop      = valid_out && ready_out;
    assign wr_ptr   = head_q ^ count_q[0];

    always_comb begin
        in_rsp.result     = result_in[grant_idx];
        in_rsp.has_fflags = has_fflags_in[grant_idx];
        in_rsp.fflags     = mask_fflags(fflags_in[grant_idx], has_fflags_in[grant_idx]);
        in_rsp.tag        = tag_in[grant_idx];
    end

    always_comb begin
        rr_d = rr_q;
        if (push) begin
            rr_d = (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign count_d = count_q + {1'b0, push} - {1'b0, pop};
    assign head_d  = head_q ^ pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q    <= '0;
            count_q <= '0;
            head_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            rr_q    <= rr_d;
            count_q <= count_d;
            head_q  <= head_d;
            if (push) begin
                buf_q[wr_ptr] <= in_rsp;
            end
        end
    end

    assign head_rsp       = buf_q[head_q];
    assign valid_out      = (count_q != 2'd0);
    assign result_out     = head_rsp.result;
    assign has_fflags_out = head_rsp.has_fflags;
    assign fflags_out     = head_rsp.fflags;
    assign tag_out        = head_rsp.tag;

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_hold_chk
        assert property (@(posedge clk) disable iff (reset)
            (valid_in[gi] && !ready_in[gi]) |=> valid_in[gi])
            else $error("valid_in[%0d] dropped before acceptance", gi);
    end

    assert property (@(posedge clk) disable iff (reset) $onehot0(grant))
        else $error("grant is not one-hot");

endmodule
